// File: rtl/mux21_arbiter.sv
// Two-requester arbiter sharing one 2:1 data mux in front of a single
// valid/ready consumer. Round-robin between A and B, with each grant capped
// at MAX_BURST beats.
module mux21_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // Count value on the beat that would hit the burst cap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    logic [1:0]       state, state_nx;
    logic             sel_nx;
    logic             prio, prio_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             xfer;

    // The shared datapath follows the registered select in every state.
    assign y_data = sel ? b_data : a_data;
    assign xfer   = y_valid & y_ready;

    // Handshake outputs; forced quiet while reset is asserted so no beat is taken in that cycle.
    always_comb begin
        y_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        busy    = 1'b0;
        if (reset_n) begin
            case (state)
                GNT_A: begin
                    y_valid = a_valid;
                    a_ready = y_ready & a_valid;
                    busy    = 1'b1;
                end
                GNT_B: begin
                    y_valid = b_valid;
                    b_ready = y_ready & b_valid;
                    busy    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Arbitration, burst counting and release with direct hand-over to the waiting side.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        prio_nx  = prio;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || !prio)) begin
                    state_nx = GNT_A;
                    sel_nx   = 1'b0;
                    cnt_nx   = '0;
                end else if (b_valid) begin
                    state_nx = GNT_B;
                    sel_nx   = 1'b1;
                    cnt_nx   = '0;
                end
            end
            GNT_A: begin
                if (xfer) begin
                    if (a_last || cnt == CNT_LAST) begin
                        prio_nx = 1'b1;
                        cnt_nx  = '0;
                        if (b_valid) begin
                            state_nx = GNT_B;
                            sel_nx   = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            GNT_B: begin
                if (xfer) begin
                    if (b_last || cnt == CNT_LAST) begin
                        prio_nx = 1'b0;
                        cnt_nx  = '0;
                        if (a_valid) begin
                            state_nx = GNT_A;
                            sel_nx   = 1'b0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            sel   <= 1'b0;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            prio  <= prio_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: doc/mux21_arbiter.md
Name: mux21_arbiter

Overview:
- Shares one 8-bit 2:1 mux datapath between two requesters, A and B, and drives a single downstream valid/ready output channel.
- A registered state machine owns the select line. It grants one requester per burst, using round-robin fairness and a burst-length cap.
- Sits directly upstream of the shared consumer. The select output is exported so the bench can cross-check the datapath.

Parameters:
WIDTH, 8, data width of each requester and of the output
MAX_BURST, 4, maximum beats per grant before forced release (legal range 1-255)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
a_data  in  WIDTH  requester A data
a_valid  in  1  requester A has a beat
a_last  in  1  A's current beat ends its burst
a_ready  out  1  A's beat accepted this cycle
b_data  in  WIDTH  requester B data
b_valid  in  1  requester B has a beat
b_last  in  1  B's current beat ends its burst
b_ready  out  1  B's beat accepted this cycle
y_data  out  WIDTH  muxed output data
y_valid  out  1  output beat valid
y_ready  in  1  downstream accepts beat
sel  out  1  mux select: 0 = A, 1 = B (registered)
busy  out  1  a grant is active

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low (reset_n), sampled on the rising edge of clk.
- State register: IDLE, GNT_A, GNT_B.
  - Also held: priority pointer prio (0 = A preferred), beat counter cnt of width clog2(MAX_BURST+1).
- Reset (reset_n = 0 at a clk edge):
  - state = IDLE, sel = 0, prio = 0, cnt = 0.
  - Outputs during and after reset: y_valid = 0, a_ready = 0, b_ready = 0, busy = 0.
  - Reset mid-burst abandons the burst immediately. No beat is accepted in the reset cycle.
- Datapath (combinational from registered sel):
  - y_data = sel ? b_data : a_data, in every state, including IDLE.
- IDLE outputs: y_valid = 0, both readies = 0, busy = 0.
  - Arbitration: only a_valid set -> GNT_A. Only b_valid set -> GNT_B. Both set -> grant prio's side.
  - The grant takes effect on the next edge, so arbitration latency is 1 cycle. sel updates on the same edge; cnt clears to 0.
- GNT_X (X = A or B) outputs:
  - y_valid = x_valid, x_ready = y_ready & x_valid, other side's ready = 0, busy = 1.
- Beat transfer = y_valid & y_ready. Each transfer increments cnt.
- Release condition: a transfer occurs and either x_last = 1 or cnt+1 == MAX_BURST.
  - On release, prio points to the other requester.
  - Other requester valid in the release cycle -> go directly to its grant state. sel flips, cnt = 0, no idle bubble.
  - Otherwise -> IDLE. sel holds its value.
- Granted requester deasserts x_valid mid-burst: the grant holds and the arbiter waits. There is no timeout, and the other requester cannot preempt.
- Downstream backpressure (y_ready = 0): the beat stays on y_data/y_valid unchanged. Both readies = 0 and cnt does not advance.
- Requester rules: data/last must stay stable while x_valid = 1 and x_ready = 0. The arbiter does not check this.
- Both requesters' last beats in the same cycle: impossible, since only one is granted. The other side's last is ignored until it is granted.
- MAX_BURST = 1: every beat releases. With both requesters valid, grants alternate A, B, A, B.

Test Plan:
- Reset check: hold reset_n = 0 for 2 cycles with both a_valid = 1 and b_valid = 1 -> y_valid = 0, a_ready = 0, b_ready = 0, sel = 0, busy = 0. After release, the first grant is A (prio = 0).
- Solo burst: A sends 8'hFF, 8'h88, 8'h39 (last = 1 on 3rd); y_ready = 1; B idle -> y_data sequence FF, 88, 39 on consecutive cycles. Returns to IDLE one cycle later with sel = 0.
- Contention and fairness: both valid continuously, A data 8'h02, B data 8'hC7, last never set, MAX_BURST = 4 -> exactly 4 A beats, then 4 B beats, repeating. sel toggles with no bubble cycle between grants.
- Backpressure: during a B grant, drop y_ready for 3 cycles with b_data = 8'hC7 -> y_valid = 1, y_data = C7, b_ready = 0 throughout, cnt unchanged. The transfer completes on the cycle y_ready returns.
- Valid gap: A granted; a_valid drops for 2 cycles while b_valid = 1 -> sel stays 0, b_ready = 0, no B beat passes. A resumes and finishes its burst, then B is granted.
- Reset mid-burst: assert reset_n = 0 after the 2nd of 4 A beats -> next cycle state = IDLE, outputs at reset values. After release with only B valid, B is granted and its first beat appears 1 cycle later.
